// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out handshake bundle for seq_bit_serializer.
// The master is the word source and the slave is the serializer.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_data;
  logic             busy;
  logic             frame_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, busy, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, busy, frame_done
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end with a one-word holding register.
// Emits one strobed bit per GAP+1 cycles, and streams consecutive words without bubbles.
//
// state   | meaning
// S_IDLE  | shifter empty, waiting for the holding register to fill
// S_SHIFT | out_valid high for the current bit
// S_GAP   | idle gap cycles after a bit, gap counter running down
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  seq_bit_serializer_if.slave bus
);
  localparam int              CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   WIDTH_C    = CW'(WIDTH);
  localparam logic [3:0]      GAP_RELOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           r_state,     w_state;
  logic [WIDTH-1:0] r_hold,      w_hold;
  logic             r_hold_full, w_hold_full;
  logic [WIDTH-1:0] r_shift,     w_shift;
  logic [CW-1:0]    r_bit_cnt,   w_bit_cnt;
  logic [3:0]       r_gap_cnt,   w_gap_cnt;
  logic             r_out_valid, w_out_valid;
  logic             r_out_data,  w_out_data;
  logic             r_frame_done, w_frame_done;
  logic             r_busy,      w_busy;
  logic             w_in_ready;
  logic             w_expire;
  logic             w_load;
  logic             w_advance;

  assign w_in_ready = !r_hold_full && !rst;

  always_comb begin
    w_state     = r_state;
    w_hold      = r_hold;
    w_hold_full = r_hold_full;
    w_shift     = r_shift;
    w_bit_cnt   = r_bit_cnt;
    w_gap_cnt   = r_gap_cnt;
    w_out_valid = 1'b0;
    w_expire    = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;

    // Capture only when the holding register is empty, so it never races a load.
    if (bus.in_valid && w_in_ready) begin
      w_hold      = bus.in_data;
      w_hold_full = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (r_hold_full) w_load = 1'b1;
      end
      S_SHIFT: begin
        if (GAP == 0) begin
          w_expire = 1'b1;
        end else begin
          w_state   = S_GAP;
          w_gap_cnt = GAP_RELOAD;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 4'd0) w_expire = 1'b1;
        else                   w_gap_cnt = r_gap_cnt - 4'd1;
      end
      default: w_state = S_IDLE;
    endcase

    if (w_expire) begin
      if (r_bit_cnt < WIDTH_C) w_advance = 1'b1;
      else if (r_hold_full)    w_load    = 1'b1;
      else                     w_state   = S_IDLE;
    end

    if (w_load) begin
      w_shift     = r_hold;
      w_hold_full = 1'b0;
      w_bit_cnt   = CW'(1);
      w_state     = S_SHIFT;
      w_out_valid = 1'b1;
    end

    if (w_advance) begin
      w_shift     = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
      w_bit_cnt   = r_bit_cnt + CW'(1);
      w_state     = S_SHIFT;
      w_out_valid = 1'b1;
    end

    w_out_data   = w_out_valid & ((MSB_FIRST != 0) ? w_shift[WIDTH-1] : w_shift[0]);
    w_frame_done = w_out_valid && (w_bit_cnt == WIDTH_C);
    w_busy       = (w_state != S_IDLE) || w_hold_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= 4'd0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_hold       <= w_hold;
      r_hold_full  <= w_hold_full;
      r_shift      <= w_shift;
      r_bit_cnt    <= w_bit_cnt;
      r_gap_cnt    <= w_gap_cnt;
      r_out_valid  <= w_out_valid;
      r_out_data   <= w_out_data;
      r_frame_done <= w_frame_done;
      r_busy       <= w_busy;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: instance A (GAP=1, MSB first), instance B (GAP=0, LSB first).
// Expected bits are queued on word acceptance; a negedge monitor pops and compares each strobe.
module tb_seq_bit_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(W)) bus_a ();
  seq_bit_serializer_if #(.WIDTH(W)) bus_b ();

  seq_bit_serializer #(.WIDTH(W), .GAP(1), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seq_bit_serializer #(.WIDTH(W), .GAP(0), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t q_a[$], q_b[$];
  int   st_a[$], st_b[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: a word becomes WIDTH bits in the configured order, the last one flagged.
  task automatic push_word(input bit sel, input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b    = sel ? w[i] : w[W-1-i];
      e.last = (i == W - 1);
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
  endtask

  task automatic monitor_step(input bit sel, input logic ov, input logic od, input logic fd);
    exp_t  e;
    string nm = sel ? "b" : "a";
    if (ov) begin
      if ((sel ? q_b.size() : q_a.size()) == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_stray: strobe with out_data=%b frame_done=%b, expected no strobe (cycle %0d)",
                 nm, od, fd, cyc);
      end else begin
        e = sel ? q_b.pop_front() : q_a.pop_front();
        check({nm, "_bit"}, 32'(od), 32'(e.b));
        check({nm, "_frame_done"}, 32'(fd), 32'(e.last));
      end
      if (sel) st_b.push_back(cyc);
      else     st_a.push_back(cyc);
    end else begin
      check({nm, "_quiet"}, {30'd0, od, fd}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      monitor_step(1'b0, bus_a.out_valid, bus_a.out_data, bus_a.frame_done);
      monitor_step(1'b1, bus_b.out_valid, bus_b.out_data, bus_b.frame_done);
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input bit sel, input logic [W-1:0] w);
    int t = 0;
    if (sel) begin bus_b.in_valid = 1'b1; bus_b.in_data = w; end
    else     begin bus_a.in_valid = 1'b1; bus_a.in_data = w; end
    while (!(sel ? bus_b.in_ready : bus_a.in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", t);
    end else begin
      push_word(sel, w);
      last_acc = cyc + 1;
    end
    @(negedge clk);
    if (sel) bus_b.in_valid = 1'b0;
    else     bus_a.in_valid = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int t = 0;
    while (((sel ? q_b.size() : q_a.size()) != 0 || (sel ? bus_b.busy : bus_a.busy)) && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    check(sel ? "b_drain_cycles_ok" : "a_drain_cycles_ok", 32'(t < 500), 32'd1);
  endtask

  task automatic check_stream(input string nm, input int s[$], input int n, input int period,
                              input int first);
    check({nm, "_strobes"}, 32'(s.size()), 32'(n));
    if (first >= 0 && s.size() > 0) check({nm, "_latency"}, 32'(s[0]), 32'(first));
    for (int i = 1; i < s.size(); i++) check({nm, "_spacing"}, 32'(s[i] - s[i-1]), 32'(period));
  endtask

  int acc1, acc2, acc3;

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready_a", 32'(bus_a.in_ready), 32'd0);
    check("rst_in_ready_b", 32'(bus_b.in_ready), 32'd0);
    check("rst_outputs_a", {28'd0, bus_a.out_valid, bus_a.out_data, bus_a.busy, bus_a.frame_done}, 32'd0);
    check("rst_outputs_b", {28'd0, bus_b.out_valid, bus_b.out_data, bus_b.busy, bus_b.frame_done}, 32'd0);
    rst = 1'b0;

    // Idle: nothing offered for 50 cycles.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_ready", {30'd0, bus_a.in_ready, bus_b.in_ready}, 32'd3);
      check("idle_busy", {30'd0, bus_a.busy, bus_b.busy}, 32'd0);
    end

    // Single word, GAP=1, MSB first.
    st_a.delete();
    send(1'b0, 8'hB4);
    acc1 = last_acc;
    drain(1'b0);
    check_stream("a_b4", st_a, 8, 2, acc1 + 1);

    // Two words back to back: one idle cycle between bit 8 and the next bit 1.
    st_a.delete();
    send(1'b0, 8'hB6);
    send(1'b0, 8'hD0);
    drain(1'b0);
    check_stream("a_b6d0", st_a, 16, 2, -1);

    // Backpressure with three queued words.
    st_a.delete();
    send(1'b0, W'($urandom)); acc1 = last_acc;
    send(1'b0, W'($urandom)); acc2 = last_acc;
    send(1'b0, W'($urandom)); acc3 = last_acc;
    drain(1'b0);
    check("bp_ready_after_load", 32'(acc2 - acc1), 32'd2);
    check("bp_ready_low_span", 32'(acc3 - acc2), 32'(W * 2));
    check_stream("a_bp", st_a, 24, 2, acc1 + 1);

    // GAP=0, LSB first.
    st_b.delete();
    send(1'b1, 8'h2D);
    acc1 = last_acc;
    drain(1'b1);
    check_stream("b_2d", st_b, 8, 1, acc1 + 1);

    st_b.delete();
    send(1'b1, W'($urandom));
    send(1'b1, W'($urandom));
    drain(1'b1);
    check_stream("b_pair", st_b, 16, 1, -1);

    // Random words with random idle time on both instances.
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      send(1'($urandom_range(0, 1)), W'($urandom));
    end
    drain(1'b0);
    drain(1'b1);

    // Reset mid-word with a second word held.
    st_a.delete();
    send(1'b0, 8'hFF);
    send(1'b0, 8'hAA);
    begin
      int t = 0;
      while (st_a.size() < 3 && t < 100) begin
        @(negedge clk);
        #1;
        t++;
      end
      check("rst_wait_third_bit", 32'(st_a.size()), 32'd3);
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", {30'd0, bus_a.out_valid, bus_a.out_data}, 32'd0);
    check("async_rst_busy", 32'(bus_a.busy), 32'd0);
    check("async_rst_ready", 32'(bus_a.in_ready), 32'd0);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("post_rst_busy", 32'(bus_a.busy), 32'd0);
    check("post_rst_ready", 32'(bus_a.in_ready), 32'd1);
    st_a.delete();
    send(1'b0, 8'h0F);
    acc1 = last_acc;
    drain(1'b0);
    check_stream("a_0f", st_a, 8, 2, acc1 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
